// File: rtl/ps2_host_tx_if.sv
// Command handshake and status signals between a PS/2 command source and
// the host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, err, err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, err, err_code
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte using the
// request-to-send sequence and checks the device ACK bit. The lines are
// open-drain; this block only produces the pull-low enables.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a command, both lines released
// INHIBIT   | PS2_CLK held low for INHIBIT_CYCLES
// RTS       | one cycle with clock and data low (start bit)
// SEND      | device clocks out start, 8 data, parity and stop
// ACK       | waiting for the device ACK on the 11th falling edge
// WAIT_IDLE | waiting for the device to release both lines
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s, clk_prev, fe;
  logic [INH_W-1:0]       inh_cnt;
  logic [WD_W-1:0]        wd_cnt;
  logic [9:0]             frame;
  logic [3:0]             bit_cnt;
  logic                   cur_bit;
  logic                   accept, wd_expire, set_timeout, set_nack;
  logic                   done_d, err_d, done_q, err_q, tx_ready_c;
  logic [1:0]             err_code_q;

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign fe        = clk_prev & ~clk_s;
  assign accept    = (state_q == IDLE) && bus.tx_valid;
  // A falling edge in the same cycle as expiry reloads the watchdog instead.
  assign wd_expire = (wd_cnt == '0) && !fe;

  // Line synchronisers and falling-edge history; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev  <= clk_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, line enables and completion strobes.
  always_comb begin
    state_d     = state_q;
    tx_ready_c  = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    set_timeout = 1'b0;
    set_nack    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_ready_c = 1'b1;
        if (bus.tx_valid) state_d = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt == '0) state_d = RTS;
      end
      RTS: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        ps2_data_oe = ~cur_bit;
        if (fe && bit_cnt == 4'd9) begin
          state_d = ACK;
        end else if (wd_expire) begin
          err_d       = 1'b1;
          set_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      ACK: begin
        if (fe) begin
          if (data_s) begin
            err_d    = 1'b1;
            set_nack = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end else if (wd_expire) begin
          err_d       = 1'b1;
          set_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wd_expire) begin
          err_d       = 1'b1;
          set_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame shifter, inhibit and watchdog down-counters, status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inh_cnt    <= '0;
      wd_cnt     <= WD_LOAD;
      frame      <= '1;
      bit_cnt    <= '0;
      cur_bit    <= 1'b1;
      err_code_q <= 2'b00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (accept) begin
        frame      <= {1'b1, ~^bus.tx_data, bus.tx_data};
        bit_cnt    <= '0;
        inh_cnt    <= INH_LOAD;
        err_code_q <= 2'b00;
      end
      if (state_q == INHIBIT && inh_cnt != '0) inh_cnt <= inh_cnt - INH_W'(1);
      if (state_q == RTS) begin
        cur_bit <= 1'b0;
        wd_cnt  <= WD_LOAD;
      end else if (state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) begin
        if (fe)                 wd_cnt <= WD_LOAD;
        else if (wd_cnt != '0)  wd_cnt <= wd_cnt - WD_W'(1);
      end
      if (state_q == SEND && fe) begin
        cur_bit <= frame[0];
        frame   <= {1'b1, frame[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (set_timeout)   err_code_q <= 2'b01;
      else if (set_nack) err_code_q <= 2'b10;
    end
  end

  assign bus.tx_ready = tx_ready_c;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the frame out, rebuilds
// the byte and checks it against a queue of accepted command bytes.
module tb_ps2_host_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic ps2_clk_i, ps2_data_i;

  int n_vec = 0, n_err = 0;
  int cyc = 0, last_fe_cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
  logic [7:0] exp_q[$];

  ps2_host_tx_if bus();

  ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(200), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pulse counters and accept monitor; accepted bytes enter the scoreboard.
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.err) err_cnt++;
    if (bus.done && bus.err) both_cnt++;
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      acc_cnt++;
      exp_q.push_back(bus.tx_data);
    end
  end

  function automatic logic [9:0] exp_oe(input logic [7:0] d);
    return {1'b0, ^d, ~d};
  endfunction

  // Device model: waits for RTS, generates nclk clock pulses (40-cycle period),
  // samples the host bits mid-low, optionally ACKs on the 11th pulse.
  task automatic dev_xfer(input int nclk, input bit ack, output logic [9:0] oe_bits,
                          output logic [7:0] rx_byte);
    int t = 0;
    logic par_line = 1'b0, stop_line = 1'b0;
    logic [7:0] e;
    oe_bits = '0;
    rx_byte = '0;
    do begin @(negedge clk); t++; end
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 2000);
    n_vec++;
    if (t >= 2000) begin
      n_err++;
      $display("FAIL rts_wait: no request-to-send within %0d cycles", t);
      return;
    end
    repeat (8) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      last_fe_cyc = cyc;
      repeat (10) @(negedge clk);
      if (k <= 10) oe_bits[k-1] = ps2_data_oe;
      if (k <= 8) rx_byte[k-1] = ps2_data_i;
      if (k == 9) par_line = ps2_data_i;
      if (k == 10) stop_line = ps2_data_i;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
      if (k == 11) dev_data_low = 1'b0;
    end
    if (nclk >= 10) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty: frame 0x%02h received with no accepted byte", rx_byte);
      end else begin
        e = exp_q.pop_front();
        if (rx_byte !== e) begin
          n_err++;
          $display("FAIL sb_byte: got 0x%02h expected 0x%02h", rx_byte, e);
        end
        n_vec++;
        if (par_line !== ~^e) begin
          n_err++;
          $display("FAIL sb_parity: got %b expected %b", par_line, ~^e);
        end
        n_vec++;
        if (stop_line !== 1'b1) begin
          n_err++;
          $display("FAIL sb_stop: got %b expected 1", stop_line);
        end
        n_vec++;
        if (oe_bits !== exp_oe(e)) begin
          n_err++;
          $display("FAIL sb_oe_bits: got %b expected %b", oe_bits, exp_oe(e));
        end
      end
    end
  endtask

  task automatic send_req(input logic [7:0] d);
    int t = 0;
    @(posedge clk); #1;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    while (!bus.tx_ready && t < 1000) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_end(input int base, input int max, output int waited);
    waited = 0;
    while ((done_cnt + err_cnt) == base && waited < max) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic test_reset;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ps2_clk_oe, ps2_data_oe, bus.tx_ready, bus.busy, bus.done, bus.err, bus.err_code} !== 8'b0010_0000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00100000",
               {ps2_clk_oe, ps2_data_oe, bus.tx_ready, bus.busy, bus.done, bus.err, bus.err_code});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ps2_clk_oe, ps2_data_oe, bus.tx_ready, bus.busy, bus.done, bus.err, bus.err_code} !== 8'b0010_0000) begin
      n_err++;
      $display("FAIL idle_outputs: got %b expected 00100000",
               {ps2_clk_oe, ps2_data_oe, bus.tx_ready, bus.busy, bus.done, bus.err, bus.err_code});
    end
  endtask

  task automatic test_basic;
    int d0 = done_cnt, e0 = err_cnt, n = 0, w;
    logic [9:0] oe;
    logic [7:0] rx;
    send_req(8'hF4);
    n_vec++;
    if ({ps2_clk_oe, ps2_data_oe, bus.busy, bus.tx_ready} !== 4'b1010) begin
      n_err++;
      $display("FAIL accept_latency: got %b expected 1010", {ps2_clk_oe, ps2_data_oe, bus.busy, bus.tx_ready});
    end
    @(negedge clk);
    while (ps2_clk_oe && !ps2_data_oe && n < 100) begin n++; @(negedge clk); end
    n_vec++;
    if (n !== 10) begin
      n_err++;
      $display("FAIL inhibit_len: got %0d expected 10", n);
    end
    n_vec++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin
      n_err++;
      $display("FAIL rts_lines: got %b expected 11", {ps2_clk_oe, ps2_data_oe});
    end
    dev_xfer(11, 1'b1, oe, rx);
    n_vec++;
    if (oe !== 10'b01_0000_1011) begin
      n_err++;
      $display("FAIL f4_oe_seq: got %b expected 0100001011", oe);
    end
    wait_end(d0 + e0, 300, w);
    repeat (3) @(negedge clk);
    n_vec++;
    if (done_cnt !== d0 + 1 || err_cnt !== e0) begin
      n_err++;
      $display("FAIL f4_done: got done %0d err %0d expected %0d %0d", done_cnt, err_cnt, d0 + 1, e0);
    end
    n_vec++;
    if ({bus.err_code, bus.tx_ready, bus.busy} !== 4'b0010) begin
      n_err++;
      $display("FAIL f4_final: got %b expected 0010", {bus.err_code, bus.tx_ready, bus.busy});
    end
  endtask

  task automatic test_parity;
    int d0 = done_cnt, e0 = err_cnt, w;
    logic [9:0] oe;
    logic [7:0] rx;
    send_req(8'hED);
    dev_xfer(11, 1'b1, oe, rx);
    n_vec++;
    if (rx !== 8'hED || oe[8] !== 1'b0) begin
      n_err++;
      $display("FAIL ed_frame: got byte 0x%02h oe9 %b expected 0xed 0", rx, oe[8]);
    end
    wait_end(d0 + e0, 300, w);
    repeat (3) @(negedge clk);
    n_vec++;
    if (done_cnt !== d0 + 1 || err_cnt !== e0) begin
      n_err++;
      $display("FAIL ed_done: got done %0d err %0d expected %0d %0d", done_cnt, err_cnt, d0 + 1, e0);
    end
  endtask

  task automatic test_nack;
    int d0 = done_cnt, e0 = err_cnt, w;
    logic [9:0] oe;
    logic [7:0] rx;
    send_req(8'h00);
    dev_xfer(11, 1'b0, oe, rx);
    wait_end(d0 + e0, 300, w);
    repeat (3) @(negedge clk);
    n_vec++;
    if (err_cnt !== e0 + 1 || done_cnt !== d0) begin
      n_err++;
      $display("FAIL nack_pulse: got err %0d done %0d expected %0d %0d", err_cnt, done_cnt, e0 + 1, d0);
    end
    n_vec++;
    if ({bus.err_code, ps2_clk_oe, ps2_data_oe, bus.tx_ready} !== 5'b10001) begin
      n_err++;
      $display("FAIL nack_state: got %b expected 10001", {bus.err_code, ps2_clk_oe, ps2_data_oe, bus.tx_ready});
    end
  endtask

  task automatic test_timeout;
    int d0 = done_cnt, e0 = err_cnt, w, lat;
    logic [9:0] oe;
    logic [7:0] rx;
    logic [7:0] drop;
    send_req(8'h5A);
    n_vec++;
    if (bus.err_code !== 2'b00) begin
      n_err++;
      $display("FAIL errcode_clear: got %b expected 00", bus.err_code);
    end
    dev_xfer(4, 1'b1, oe, rx);
    if (exp_q.size() > 0) drop = exp_q.pop_front();
    wait_end(d0 + e0, 400, w);
    lat = cyc - last_fe_cyc;
    n_vec++;
    if (w >= 400 || lat < 195 || lat > 215) begin
      n_err++;
      $display("FAIL timeout_latency: got %0d cycles after fe4 expected about 200", lat);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.err_code, ps2_clk_oe, ps2_data_oe, bus.tx_ready, bus.busy} !== 6'b010010) begin
      n_err++;
      $display("FAIL timeout_state: got %b expected 010010",
               {bus.err_code, ps2_clk_oe, ps2_data_oe, bus.tx_ready, bus.busy});
    end
    n_vec++;
    if (err_cnt !== e0 + 1 || done_cnt !== d0) begin
      n_err++;
      $display("FAIL timeout_pulse: got err %0d done %0d expected %0d %0d", err_cnt, done_cnt, e0 + 1, d0);
    end
  endtask

  task automatic test_reset_mid;
    int d0 = done_cnt, e0 = err_cnt, w;
    logic [9:0] oe;
    logic [7:0] rx;
    logic [7:0] drop;
    send_req(8'h3C);
    dev_xfer(5, 1'b1, oe, rx);
    if (exp_q.size() > 0) drop = exp_q.pop_front();
    @(negedge clk);
    n_vec++;
    if (!bus.busy) begin
      n_err++;
      $display("FAIL mid_busy: got busy %b expected 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      n_err++;
      $display("FAIL async_release: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.tx_ready, bus.err_code} !== 3'b100 || done_cnt !== d0 || err_cnt !== e0) begin
      n_err++;
      $display("FAIL post_reset: got ready/code %b done %0d err %0d expected 100 %0d %0d",
               {bus.tx_ready, bus.err_code}, done_cnt, err_cnt, d0, e0);
    end
    send_req(8'hFF);
    dev_xfer(11, 1'b1, oe, rx);
    n_vec++;
    if (oe[8] !== 1'b0) begin
      n_err++;
      $display("FAIL ff_parity_oe: got %b expected 0", oe[8]);
    end
    wait_end(d0 + e0, 300, w);
    repeat (3) @(negedge clk);
    n_vec++;
    if (done_cnt !== d0 + 1 || err_cnt !== e0) begin
      n_err++;
      $display("FAIL ff_done: got done %0d err %0d expected %0d %0d", done_cnt, err_cnt, d0 + 1, e0);
    end
  endtask

  task automatic test_back_to_back;
    int a0 = acc_cnt, d0 = done_cnt, e0 = err_cnt, t = 0, w;
    logic [9:0] oe;
    logic [7:0] rx;
    @(posedge clk); #1;
    bus.tx_data  = 8'h12;
    bus.tx_valid = 1'b1;
    while (acc_cnt == a0 && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    bus.tx_data = 8'h34;
    dev_xfer(11, 1'b1, oe, rx);
    n_vec++;
    if (acc_cnt !== a0 + 1) begin
      n_err++;
      $display("FAIL b2b_single_accept: got %0d accepts expected %0d", acc_cnt - a0, 1);
    end
    t = 0;
    while (acc_cnt < a0 + 2 && t < 300) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    n_vec++;
    if (done_cnt !== d0 + 1) begin
      n_err++;
      $display("FAIL b2b_order: got done %0d at second accept expected %0d", done_cnt, d0 + 1);
    end
    dev_xfer(11, 1'b1, oe, rx);
    wait_end(d0 + e0 + 1, 300, w);
    repeat (3) @(negedge clk);
    n_vec++;
    if (acc_cnt !== a0 + 2 || done_cnt !== d0 + 2 || err_cnt !== e0) begin
      n_err++;
      $display("FAIL b2b_totals: got acc %0d done %0d err %0d expected %0d %0d %0d",
               acc_cnt - a0, done_cnt - d0, err_cnt - e0, 2, 2, 0);
    end
    n_vec++;
    if (both_cnt !== 0) begin
      n_err++;
      $display("FAIL done_err_overlap: got %0d cycles expected 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete by time %0t", $time);
    $fatal(1, "bench time limit");
  end
endmodule
